instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the control/decode unit.
- Owns the PC and issues requests to instruction memory over a req/gnt/rvalid handshake, with at most one request outstanding.
- Buffers returned words and presents them to decode with a valid/ready handshake; if_OP drives the control unit's OP input.
- Takes branch/jump redirects from execute and squashes wrong-path fetches.

Parameters:
- ADDR_W, 32, PC and instruction-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when nothing is valid (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- IM_req  out  1  instruction-memory request
- IM_addr  out  ADDR_W  request address, always word-aligned
- IM_gnt  in  1  memory accepts the request this cycle
- IM_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt
- IM_rdata  in  32  instruction word
- redirect  in  1  taken branch or jump this cycle
- redirect_pc  in  ADDR_W  target address for the redirect
- id_ready  in  1  decode accepts if_instr this cycle
- if_valid  out  1  if_instr/if_pc/if_OP are valid
- if_instr  out  32  fetched instruction
- if_pc  out  ADDR_W  address of if_instr
- if_OP  out  7  if_instr[6:0], feeds control OP

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=IDLE, skid empty, if_valid=0, if_instr=NOP_INSTR, if_pc=RESET_PC. IM_req=0 in the cycle after reset; IM_addr follows pc.
- Reset mid-request: the outstanding request is forgotten. Any rvalid arriving after reset is ignored unless state=WAIT.
- FSM states: IDLE, WAIT, DROP.
- IDLE: IM_req = !redirect && skid empty; IM_addr = pc. On IM_req && IM_gnt: req_pc<=pc, pc<=pc+4 (wraps modulo 2^ADDR_W), next state WAIT. Without gnt, IM_req and IM_addr are held stable.
- WAIT: IM_req=0. On IM_rvalid, the word with req_pc is delivered, then next state IDLE:
  - to the output register if !if_valid || id_ready;
  - otherwise to the skid.
- DROP: IM_req=0. On IM_rvalid, the data is discarded and next state is IDLE.
- Decode handshake: a transfer occurs when if_valid && id_ready. On transfer:
  - if the skid is full, skid moves to output and the skid empties;
  - else if a delivery arrives the same cycle, it loads the output;
  - else if_valid<=0 and if_instr<=NOP_INSTR.
- Output is held stable while if_valid && !id_ready.
- Redirect has priority over all of the above:
  - pc<=redirect_pc with bits[1:0] forced to 0;
  - if_valid<=0 and skid cleared;
  - IM_req is forced 0 combinationally that cycle.
- Redirect state changes:
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid the same cycle: data is discarded, go to IDLE.
  - DROP: stays DROP until rvalid.
- Latency (zero-wait memory, gnt same cycle, rvalid next cycle): redirect in cycle N gives IM_req at N+1, rvalid at N+2, and if_valid=1 with the target word at N+3.
- Steady-state throughput: 1 instruction per 2 cycles.
- Invariant: at most one outstanding request, and output + skid hold at most 2 words. No word is dropped or duplicated except by redirect.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants RTYPE, ITYPE, ITYPE_LW, STYPE, BTYPE, UTYPE, JTYPE;
  - NOP_INSTR;
  - typedef fetch_state_e {IDLE, WAIT, DROP};
  - typedef fetch_pkt_t {instr, pc}.
- Sub-module fetch_skid_buf: one-entry buffer of fetch_pkt_t with push/pop/flush/full.

Test Plan:
- Reset then zero-wait memory returning IM_rdata=addr^32'hA5A5_0000, id_ready=1 -> IM_addr sequence 0,4,8,C; if_pc 0,4,8 in order with matching if_instr; if_valid first high 3 cycles after rst falls.
- id_ready=0 for 6 cycles after the first word -> if_instr/if_pc at 0 held stable. Exactly one extra word (pc=4) goes to the skid, and IM_req stays 0 while the skid is full. After id_ready=1, words 0,4,8 are delivered with none lost.
- gnt delayed 3 cycles -> IM_req=1 and IM_addr=0x8 held constant all 3 cycles; one grant yields one word.
- redirect=1, redirect_pc=0x100 while in WAIT for addr 0x10, rvalid 2 cycles later -> word for 0x10 never appears on if_valid. Next IM_addr=0x100, and if_pc=0x100 is delivered.
- redirect with redirect_pc=0x203 in the same cycle as rvalid -> data discarded, next IM_addr=0x200.
- pc=32'hFFFF_FFFC fetched -> next IM_addr=0x0 (wrap). rst asserted while in DROP -> if_valid=0 and IM_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared front-end definitions: RV32 opcode classes, the fetch FSM encoding and
// the instruction/PC packet passed between fetch and decode.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] RTYPE    = 7'b0110011;
  localparam logic [OP_W-1:0] ITYPE    = 7'b0010011;
  localparam logic [OP_W-1:0] ITYPE_LW = 7'b0000011;
  localparam logic [OP_W-1:0] STYPE    = 7'b0100011;
  localparam logic [OP_W-1:0] BTYPE    = 7'b1100011;
  localparam logic [OP_W-1:0] UTYPE    = 7'b0110111;
  localparam logic [OP_W-1:0] JTYPE    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus: req/gnt address phase, rvalid data phase.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic                        IM_req;
  logic [ADDR_W-1:0]           IM_addr;
  logic                        IM_gnt;
  logic                        IM_rvalid;
  logic [core_pkg::XLEN-1:0]   IM_rdata;

  modport master (
    output IM_req,
    output IM_addr,
    input  IM_gnt,
    input  IM_rvalid,
    input  IM_rdata
  );

  modport slave (
    input  IM_req,
    input  IM_addr,
    output IM_gnt,
    output IM_rvalid,
    output IM_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that decode could not take yet.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic       full
);

  // Flush wins over push so a squashed word never survives a redirect.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (push) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one memory request in flight and
// feeds decode through an output register backed by a one-entry skid buffer.
module instr_fetch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      im,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [6:0]         if_OP
);

  import core_pkg::*;

  fetch_state_e      state;
  fetch_state_e      state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;

  logic       req_c;
  logic       grant;
  logic       deliver;
  logic       xfer;
  logic       to_out;
  logic       to_skid;
  logic       skid_pop;
  logic       skid_full;
  fetch_pkt_t rsp_pkt;
  fetch_pkt_t skid_dout;
  logic       unused_redirect_lsb;

  // Next state and request; a redirect or a full skid suppresses new requests.
  always_comb begin
    state_nx = state;
    req_c    = 1'b0;
    case (state)
      IDLE: begin
        req_c = !rst && !redirect && !skid_full;
        if (req_c && im.IM_gnt) state_nx = WAIT;
      end
      WAIT: begin
        if (im.IM_rvalid)  state_nx = IDLE;
        else if (redirect) state_nx = DROP;
      end
      DROP: begin
        if (im.IM_rvalid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign im.IM_req  = req_c;
  assign im.IM_addr = pc;

  assign grant    = req_c && im.IM_gnt;
  assign deliver  = (state == WAIT) && im.IM_rvalid && !redirect;
  assign xfer     = if_valid && id_ready;
  assign to_out   = deliver && (!if_valid || id_ready);
  assign to_skid  = deliver && if_valid && !id_ready;
  assign skid_pop = xfer && skid_full && !redirect;
  assign rsp_pkt  = '{instr: im.IM_rdata, pc: XLEN'(req_pc)};
  assign if_OP    = if_instr[6:0];

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Redirect targets are forced word-aligned; sequential fetch wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (grant) begin
      req_pc <= pc;
      pc     <= pc + ADDR_W'(4);
    end
  end

  // Output register: skid drains first, then a fresh delivery, else go empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (xfer && skid_full) begin
      if_valid <= 1'b1;
      if_instr <= skid_dout.instr;
      if_pc    <= ADDR_W'(skid_dout.pc);
    end else if (to_out) begin
      if_valid <= 1'b1;
      if_instr <= rsp_pkt.instr;
      if_pc    <= ADDR_W'(rsp_pkt.pc);
    end else if (xfer) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (to_skid),
    .pop   (skid_pop),
    .flush (redirect),
    .din   (rsp_pkt),
    .dout  (skid_dout),
    .full  (skid_full)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory and an in-order expected-word queue
// drive directed scenarios and a randomized redirect/back-pressure run.
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_OP;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W)) im ();

  instr_fetch #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im          (im),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_OP       (if_OP)
  );

  // memory model
  bit          mem_pend = 0;
  logic [31:0] mem_addr;
  int          mem_cnt  = 0;
  int          rv_lat   = 1;
  bit          rand_gnt = 0;
  logic [31:0] deny_addr = 32'hFFFF_FFFF;
  int          deny_n   = 0;
  int          deny_cnt = 0;

  // expected words granted and not yet consumed, and consumed pcs
  logic [31:0] expq[$];
  logic [31:0] got[$];

  // per-cycle observations
  logic        o_req, o_valid, o_rv;
  logic [31:0] o_addr, o_instr, o_pc;
  logic [6:0]  o_op;
  bit          o_gnt;

  logic        p_req = 0, p_valid = 0, p_ready = 0, p_red = 0, p_rst = 1;
  bit          p_gnt = 0;
  logic [31:0] p_addr = 0, p_instr = 0, p_pc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // One clock cycle: inputs set by caller, memory responds, edge, model update.
  task automatic step();
    logic [31:0] e;
    logic [31:0] w;
    if (mem_pend && mem_cnt == 0) begin
      im.IM_rvalid = 1'b1;
      im.IM_rdata  = mem_word(mem_addr);
    end else begin
      im.IM_rvalid = 1'b0;
      im.IM_rdata  = $urandom;
    end
    im.IM_gnt = 1'b0;
    #1;
    o_req = im.IM_req; o_addr = im.IM_addr; o_rv = im.IM_rvalid;
    o_valid = if_valid; o_instr = if_instr; o_pc = if_pc; o_op = if_OP;
    if (o_req === 1'b1) begin
      if (rand_gnt) o_gnt = ($urandom_range(0, 2) != 0);
      else if (o_addr == deny_addr && deny_cnt < deny_n) begin
        o_gnt = 0;
        deny_cnt++;
      end else o_gnt = 1;
    end else o_gnt = bit'($urandom_range(0, 1));
    im.IM_gnt = o_gnt;

    if (!p_rst && !p_red && p_valid && !p_ready) begin
      checks++;
      if (o_valid !== 1'b1 || o_pc !== p_pc || o_instr !== p_instr) begin
        errors++;
        $display("FAIL out_hold: valid=%b pc=%h instr=%h, required 1 %h %h",
                 o_valid, o_pc, o_instr, p_pc, p_instr);
      end
    end
    if (p_req && !p_gnt && !redirect && !rst) begin
      checks++;
      if (o_req !== 1'b1 || o_addr !== p_addr) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h, required 1 %h", o_req, o_addr, p_addr);
      end
    end
    if (o_req === 1'b1) begin
      checks++;
      if (mem_pend || o_addr[1:0] != 2'b00) begin
        errors++;
        $display("FAIL req_legal: outstanding=%b addr=%h, required 0 and aligned",
                 mem_pend, o_addr);
      end
    end
    if (!rst && o_valid === 1'b1 && id_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: pc=%h instr=%h, required no word", o_pc, o_instr);
      end else begin
        e = expq.pop_front();
        w = mem_word(e);
        if (o_pc !== e || o_instr !== w || o_op !== w[6:0]) begin
          errors++;
          $display("FAIL xfer_word: pc=%h instr=%h op=%h, required %h %h %h",
                   o_pc, o_instr, o_op, e, w, w[6:0]);
        end
      end
      got.push_back(o_pc);
    end

    @(posedge clk);
    if (rst) begin
      expq.delete();
      mem_pend = 0;
    end else begin
      if (o_rv) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (redirect) expq.delete();
      if (o_req === 1'b1 && o_gnt) begin
        mem_pend = 1;
        mem_addr = o_addr;
        mem_cnt  = rv_lat - 1;
        expq.push_back(o_addr);
      end
    end
    checks++;
    if (expq.size() > 2) begin
      errors++;
      $display("FAIL occupancy: %0d words pending, required at most 2", expq.size());
    end
    p_req = o_req; p_gnt = o_gnt; p_addr = o_addr; p_valid = o_valid;
    p_ready = id_ready; p_instr = o_instr; p_pc = o_pc; p_red = redirect; p_rst = rst;
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic ry);
    rst = r; redirect = rd; redirect_pc = rp; id_ready = ry;
    step();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    got.delete();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    checks++;
    if (o_valid !== 1'b0 || o_instr !== NOP || o_pc !== RST_PC) begin
      errors++;
      $display("FAIL reset_out: valid=%b instr=%h pc=%h, required 0 %h %h",
               o_valid, o_instr, o_pc, NOP, RST_PC);
    end
    checks++;
    if (o_req !== 1'b0 || o_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_req: req=%b addr=%h, required 0 %h", o_req, o_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic        rq[1:8];
    logic        vl[1:8];
    logic [31:0] ad[1:8];
    logic [31:0] pcs[1:8];
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 1);
      rq[k] = o_req; vl[k] = o_valid; ad[k] = o_addr; pcs[k] = o_pc;
    end
    for (int k = 1; k <= 7; k += 2) begin
      checks++;
      if (rq[k] !== 1'b1 || ad[k] !== 32'((k - 1) * 2)) begin
        errors++;
        $display("FAIL stream_addr: step %0d req=%b addr=%h, required 1 %h",
                 k, rq[k], ad[k], 32'((k - 1) * 2));
      end
    end
    checks++;
    if (vl[1] !== 1'b0 || vl[2] !== 1'b0 || vl[3] !== 1'b1 || pcs[3] !== 32'h0) begin
      errors++;
      $display("FAIL stream_latency: valid %b%b%b pc=%h, required 001 00000000",
               vl[1], vl[2], vl[3], pcs[3]);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      errors++;
      $display("FAIL stream_order: %0d words first=%h, required 3 words 0,4,8",
               got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    for (int k = 3; k <= 8; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== mem_word(32'h0)) begin
        errors++;
        $display("FAIL bp_hold: step %0d valid=%b pc=%h, required 1 00000000",
                 k, o_valid, o_pc);
      end
      if (k >= 5) begin
        checks++;
        if (o_req !== 1'b0) begin
          errors++;
          $display("FAIL bp_skid_full_req: step %0d req=%b, required 0", k, o_req);
        end
      end
    end
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 1);
    checks++;
    if (got.size() < 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      errors++;
      $display("FAIL bp_drain: %0d words, required at least 0,4,8 in order", got.size());
    end
  endtask

  task automatic test_gnt_delay();
    int first = -1;
    int last  = -1;
    int held  = 0;
    int g8    = 0;
    int n8    = 0;
    do_reset();
    deny_addr = 32'h8; deny_n = 3; deny_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      drive(0, 0, 0, 1);
      if (o_req === 1'b1 && o_addr == 32'h8) begin
        held++;
        if (first < 0) first = k;
        last = k;
        if (o_gnt) g8++;
      end
    end
    deny_n = 0;
    foreach (got[i]) if (got[i] == 32'h8) n8++;
    checks++;
    if (held != 4 || last - first != 3 || g8 != 1) begin
      errors++;
      $display("FAIL gnt_delay_req: req cycles=%0d span=%0d grants=%0d, required 4 3 1",
               held, last - first, g8);
    end
    checks++;
    if (n8 != 1) begin
      errors++;
      $display("FAIL gnt_delay_word: pc 8 delivered %0d times, required 1", n8);
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 0;
    do_reset();
    rv_lat = 3;
    for (int k = 0; k < 40 && !found; k++) begin
      drive(0, 0, 0, 1);
      if (o_req === 1'b1 && o_gnt && o_addr == 32'h10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_wait_grant: grant for 00000010 seen=%b, required 1", found);
    end
    drive(0, 1, 32'h100, 0);
    got.delete();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(0, 0, 0, 1);
      if (o_req === 1'b1) found = 1;
    end
    checks++;
    if (!found || o_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_wait_addr: req=%b addr=%h, required 1 00000100", found, o_addr);
    end
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 1);
    checks++;
    if (got.size() == 0 || got[0] !== 32'h100) begin
      errors++;
      $display("FAIL redir_wait_word: first pc=%h, required 00000100",
               (got.size() > 0) ? got[0] : 32'hx);
    end
    rv_lat = 1;
  endtask

  task automatic test_redirect_rvalid();
    bit found = 0;
    do_reset();
    for (int k = 0; k < 10 && !found; k++) begin
      drive(0, 0, 0, 1);
      if (o_req === 1'b1 && o_gnt) found = 1;
    end
    drive(0, 1, 32'h203, 0);
    checks++;
    if (!found || o_rv !== 1'b1) begin
      errors++;
      $display("FAIL redir_rv_setup: grant=%b rvalid=%b, required 1 1", found, o_rv);
    end
    got.delete();
    drive(0, 0, 0, 1);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_rv_addr: req=%b addr=%h, required 1 00000200", o_req, o_addr);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    checks++;
    if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instr !== mem_word(32'h200)) begin
      errors++;
      $display("FAIL redir_latency: valid=%b pc=%h instr=%h, required 1 00000200 %h",
               o_valid, o_pc, o_instr, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 32'hFFFF_FFFC, 0);
    got.delete();
    drive(0, 0, 0, 1);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: req=%b addr=%h, required 1 fffffffc", o_req, o_addr);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h, required 1 00000000", o_req, o_addr);
    end
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1);
    checks++;
    if (got.size() < 2 || got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_words: %0d words, required fffffffc then 00000000", got.size());
    end
  endtask

  task automatic test_reset_in_drop();
    bit found = 0;
    do_reset();
    rv_lat = 4;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(0, 0, 0, 1);
      if (o_req === 1'b1 && o_gnt) found = 1;
    end
    drive(0, 1, 32'h40, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (!found || o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_drop: grant=%b valid=%b req=%b addr=%h, required 1 0 1 %h",
               found, o_valid, o_req, o_addr, RST_PC);
    end
    rv_lat = 1;
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic rd;
    do_reset();
    rand_gnt = 1;
    for (int k = 0; k < 600; k++) begin
      rv_lat = $urandom_range(1, 3);
      rd = ($urandom_range(0, 19) == 0);
      drive(0, rd, $urandom, rd ? 1'b0 : ($urandom_range(0, 3) != 0));
    end
    rand_gnt = 0;
    rv_lat = 1;
    checks++;
    if (got.size() < 40) begin
      errors++;
      $display("FAIL random_progress: %0d words delivered, required at least 40", got.size());
    end
  endtask

  initial begin
    rst = 1; redirect = 0; redirect_pc = 0; id_ready = 0;
    im.IM_gnt = 0; im.IM_rvalid = 0; im.IM_rdata = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_delay();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_in_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
